// File: rtl/cnn_datapath_gen.sv
// ============================================================================
// cnn_datapath_gen
// ----------------------------------------------------------------------------
// Parametrised datapath for the CNN16 processor family. It provides:
//   - an NREG-entry register file R[0..NREG-1]
//   - an accumulator AC fed by an internal 8-function ALU (a = AC, b = bus)
//   - a program counter PC and an address register AR (drives mem_addr)
//   - auto-wrapping X/Y scan counters with a one-cycle frame_done pulse
//   - a multi-cycle signed MAC sequencer: AC = fit(sum(mem[AR+k*stride] * R[k]))
// The control unit drives the load/select strobes. Memory is synchronous with
// a 1-cycle read latency.
//
// Optional feature (compile-time macro):
//   CNN_MAC_SAT_EN  defined   : MAC result saturates to the signed DW range
//                   undefined : MAC result keeps the low DW bits (wraps)
//   ALU operations are not affected by the macro.
//
// Parameters:
//   DW   data / bus width
//   AW   PC and AR width
//   NREG register file depth, also the maximum MAC tap count
//   IW   X/Y counter width (2*IW <= DW)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_bus_sel       bus source: R[n] | AC | mem_rdata | PC | {Y,X} | 0
//   i_rf_load/sel   write bus into R[i_rf_sel]
//   i_ac_load       load ALU result (op i_alu_op) into AC
//   i_pc_load/inc   PC <= bus (priority) or PC+1
//   i_ar_load/inc   AR <= bus (priority) or AR+1
//   i_ar_stride     AR increment applied by each MAC fetch
//   i_xy_step/clr   scan counter step / clear (clear has priority)
//   i_x_max/y_max   inclusive wrap bounds of X and Y
//   i_mac_start     MAC start pulse, i_mac_taps = tap count 0..NREG
//   i_mem_rdata     memory read data (valid the cycle after o_mem_rd)
//   o_mem_addr      = AR
//   o_mem_rd        read strobe (MAC fetch cycles)
//   o_mem_wdata     = bus
//   o_busy          MAC in FETCH/ACC
//   o_mac_done      one-cycle MAC completion flag
//   o_frame_done    one-cycle pulse after the scan wraps Y back to 0
//   o_ac_value, o_pc_value, o_x_value, o_y_value   state visibility
// ============================================================================
module cnn_datapath_gen #(
    parameter int DW   = 16,
    parameter int AW   = 12,
    parameter int NREG = 8,
    parameter int IW   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(NREG+4)-1:0]   i_bus_sel,
    input  logic                        i_rf_load,
    input  logic [$clog2(NREG)-1:0]     i_rf_sel,
    input  logic                        i_ac_load,
    input  logic [2:0]                  i_alu_op,
    input  logic                        i_pc_load,
    input  logic                        i_pc_inc,
    input  logic                        i_ar_load,
    input  logic                        i_ar_inc,
    input  logic [AW-1:0]               i_ar_stride,
    input  logic                        i_xy_step,
    input  logic                        i_xy_clr,
    input  logic [IW-1:0]               i_x_max,
    input  logic [IW-1:0]               i_y_max,
    input  logic                        i_mac_start,
    input  logic [$clog2(NREG+1)-1:0]   i_mac_taps,
    input  logic [DW-1:0]               i_mem_rdata,
    output logic [AW-1:0]               o_mem_addr,
    output logic                        o_mem_rd,
    output logic [DW-1:0]               o_mem_wdata,
    output logic                        o_busy,
    output logic                        o_mac_done,
    output logic                        o_frame_done,
    output logic [DW-1:0]               o_ac_value,
    output logic [AW-1:0]               o_pc_value,
    output logic [IW-1:0]               o_x_value,
    output logic [IW-1:0]               o_y_value
);

    // ------------------------------------------------------------------------
    // MAC sequencer states
    //   state | meaning
    //   IDLE  | waiting for i_mac_start
    //   FETCH | o_mem_rd=1 at AR, AR advances by stride at the edge
    //   ACC   | acc += mem_rdata * R[cnt]; loop to FETCH or write AC
    //   DONE  | o_mac_done=1 for one cycle; accepts a new start like IDLE
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ACC   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int RW  = $clog2(NREG);
    localparam int SW  = $clog2(NREG + 4);
    localparam int TW  = $clog2(NREG + 1);
    // Wide enough to hold NREG full-scale signed products without overflow.
    localparam int ACW = 2 * DW + RW;

    localparam logic [SW-1:0] SEL_AC  = SW'(NREG);
    localparam logic [SW-1:0] SEL_MEM = SW'(NREG + 1);
    localparam logic [SW-1:0] SEL_PC  = SW'(NREG + 2);
    localparam logic [SW-1:0] SEL_XY  = SW'(NREG + 3);

    logic [DW-1:0]          r_rf [NREG];
    logic [DW-1:0]          r_ac;
    logic [AW-1:0]          r_pc;
    logic [AW-1:0]          r_ar;
    logic [IW-1:0]          r_x;
    logic [IW-1:0]          r_y;
    logic                   r_frame_done;

    logic [1:0]             r_state;
    logic signed [ACW-1:0]  r_acc;
    logic [TW-1:0]          r_cnt;
    logic [TW-1:0]          r_taps;

    logic [DW-1:0]          w_bus;
    logic [DW-1:0]          w_alu;
    logic                   w_busy;
    logic                   w_accept;
    logic                   w_start_taps;
    logic                   w_start_zero;
    logic [TW-1:0]          w_cnt_nxt;
    logic                   w_more;
    logic                   w_acc_last;
    logic signed [2*DW-1:0] w_prod;
    logic signed [ACW-1:0]  w_sum;
    logic [DW-1:0]          w_fit;

    // ------------------------------------------------------------------------
    // Bus source mux
    // ------------------------------------------------------------------------
    always_comb begin
        w_bus = '0;
        if (i_bus_sel < SEL_AC) begin
            w_bus = r_rf[i_bus_sel[RW-1:0]];
        end else if (i_bus_sel == SEL_AC) begin
            w_bus = r_ac;
        end else if (i_bus_sel == SEL_MEM) begin
            w_bus = i_mem_rdata;
        end else if (i_bus_sel == SEL_PC) begin
            w_bus = DW'(r_pc);
        end else if (i_bus_sel == SEL_XY) begin
            w_bus = DW'({r_y, r_x});
        end
    end

    // ------------------------------------------------------------------------
    // ALU, a = AC, b = bus, results wrap modulo 2^DW
    // ------------------------------------------------------------------------
    always_comb begin
        w_alu = '0;
        case (i_alu_op)
            3'd0:    w_alu = r_ac + w_bus;
            3'd1:    w_alu = r_ac - w_bus;
            3'd2:    w_alu = r_ac & w_bus;
            3'd3:    w_alu = r_ac | w_bus;
            3'd4:    w_alu = r_ac ^ w_bus;
            3'd5:    w_alu = w_bus;
            3'd6:    w_alu = r_ac << 1;
            default: w_alu = DW'($signed(r_ac) >>> 1);
        endcase
    end

    // ------------------------------------------------------------------------
    // MAC arithmetic
    // ------------------------------------------------------------------------
    assign w_busy       = (r_state == S_FETCH) || (r_state == S_ACC);
    // DONE behaves like IDLE for accepting a new start (back-to-back MACs).
    assign w_accept     = i_mac_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_start_taps = w_accept && (i_mac_taps != '0);
    assign w_start_zero = w_accept && (i_mac_taps == '0);

    assign w_cnt_nxt  = r_cnt + TW'(1);
    assign w_more     = (w_cnt_nxt < r_taps);
    assign w_acc_last = (r_state == S_ACC) && !w_more;

    assign w_prod = $signed(i_mem_rdata) * $signed(r_rf[r_cnt[RW-1:0]]);
    assign w_sum  = r_acc + {{(ACW - 2*DW){w_prod[2*DW-1]}}, w_prod};

`ifdef CNN_MAC_SAT_EN
    localparam logic signed [ACW-1:0] SAT_MAX = {{(ACW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACW-1:0] SAT_MIN = {{(ACW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    always_comb begin
        w_fit = w_sum[DW-1:0];
        if (w_sum > SAT_MAX) begin
            w_fit = SAT_MAX[DW-1:0];
        end else if (w_sum < SAT_MIN) begin
            w_fit = SAT_MIN[DW-1:0];
        end
    end
`else
    assign w_fit = w_sum[DW-1:0];
`endif

    // ------------------------------------------------------------------------
    // MAC sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_taps  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_taps) begin
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_taps  <= i_mac_taps;
                        r_state <= S_FETCH;
                    end else if (w_start_zero) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    r_state <= S_ACC;
                end
                S_ACC: begin
                    r_acc <= w_sum;
                    r_cnt <= w_cnt_nxt;
                    if (w_more) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (i_rf_load && !w_busy) begin
            r_rf[i_rf_sel] <= w_bus;
        end
    end

    // ------------------------------------------------------------------------
    // Accumulator: MAC writes win over a same-cycle ac_load
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ac <= '0;
        end else if (w_start_zero) begin
            r_ac <= '0;
        end else if (w_acc_last) begin
            r_ac <= w_fit;
        end else if (i_ac_load && !w_busy) begin
            r_ac <= w_alu;
        end
    end

    // ------------------------------------------------------------------------
    // Program counter (keeps running while the MAC is busy)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else if (i_pc_load) begin
            r_pc <= w_bus[AW-1:0];
        end else if (i_pc_inc) begin
            r_pc <= r_pc + AW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Address register: MAC stepping > load > increment
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ar <= '0;
        end else if (r_state == S_FETCH) begin
            r_ar <= r_ar + i_ar_stride;
        end else if (i_ar_load && !w_busy) begin
            r_ar <= w_bus[AW-1:0];
        end else if (i_ar_inc && !w_busy) begin
            r_ar <= r_ar + AW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // X/Y scan counters; frame_done is registered so it appears together
    // with the wrapped (0,0) position.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (i_xy_clr) begin
                r_x <= '0;
                r_y <= '0;
            end else if (i_xy_step) begin
                if (r_x != i_x_max) begin
                    r_x <= r_x + IW'(1);
                end else begin
                    r_x <= '0;
                    if (r_y != i_y_max) begin
                        r_y <= r_y + IW'(1);
                    end else begin
                        r_y          <= '0;
                        r_frame_done <= 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_mem_addr   = r_ar;
    assign o_mem_rd     = (r_state == S_FETCH);
    assign o_mem_wdata  = w_bus;
    assign o_busy       = w_busy;
    assign o_mac_done   = (r_state == S_DONE);
    assign o_frame_done = r_frame_done;
    assign o_ac_value   = r_ac;
    assign o_pc_value   = r_pc;
    assign o_x_value    = r_x;
    assign o_y_value    = r_y;

endmodule

// File: tb/tb_cnn_datapath_gen.sv
// ============================================================================
// tb_cnn_datapath_gen
// ----------------------------------------------------------------------------
// Self-checking bench for cnn_datapath_gen with default parameters. A 1-cycle
// latency memory model feeds i_mem_rdata; a force path lets the bench put an
// arbitrary value on the bus (via the mem_rdata bus source) to preload
// registers. Expected MAC results go into a queue when a MAC is started and
// are popped when the DUT raises mac_done.
// ============================================================================
module tb_cnn_datapath_gen;

    localparam int DW   = 16;
    localparam int AW   = 12;
    localparam int NREG = 8;
    localparam int IW   = 8;

    logic        clk;
    logic        rst;
    logic [3:0]  bus_sel;
    logic        rf_load;
    logic [2:0]  rf_sel;
    logic        ac_load;
    logic [2:0]  alu_op;
    logic        pc_load;
    logic        pc_inc;
    logic        ar_load;
    logic        ar_inc;
    logic [11:0] ar_stride;
    logic        xy_step;
    logic        xy_clr;
    logic [7:0]  x_max;
    logic [7:0]  y_max;
    logic        mac_start;
    logic [3:0]  mac_taps;
    wire  [15:0] mem_rdata;
    wire  [11:0] mem_addr;
    wire         mem_rd;
    wire  [15:0] mem_wdata;
    wire         busy;
    wire         mac_done;
    wire         frame_done;
    wire  [15:0] ac_value;
    wire  [11:0] pc_value;
    wire  [7:0]  x_value;
    wire  [7:0]  y_value;

    logic [15:0] mem [0:4095];
    logic [15:0] mem_q;
    logic        force_en;
    logic [15:0] force_val;

    logic [15:0] exp_q [$];
    int          checks;
    int          errors;

    assign mem_rdata = force_en ? force_val : mem_q;

    always @(posedge clk) begin
        if (mem_rd) mem_q <= mem[mem_addr];
    end

    cnn_datapath_gen #(.DW(DW), .AW(AW), .NREG(NREG), .IW(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_bus_sel    (bus_sel),
        .i_rf_load    (rf_load),
        .i_rf_sel     (rf_sel),
        .i_ac_load    (ac_load),
        .i_alu_op     (alu_op),
        .i_pc_load    (pc_load),
        .i_pc_inc     (pc_inc),
        .i_ar_load    (ar_load),
        .i_ar_inc     (ar_inc),
        .i_ar_stride  (ar_stride),
        .i_xy_step    (xy_step),
        .i_xy_clr     (xy_clr),
        .i_x_max      (x_max),
        .i_y_max      (y_max),
        .i_mac_start  (mac_start),
        .i_mac_taps   (mac_taps),
        .i_mem_rdata  (mem_rdata),
        .o_mem_addr   (mem_addr),
        .o_mem_rd     (mem_rd),
        .o_mem_wdata  (mem_wdata),
        .o_busy       (busy),
        .o_mac_done   (mac_done),
        .o_frame_done (frame_done),
        .o_ac_value   (ac_value),
        .o_pc_value   (pc_value),
        .o_x_value    (x_value),
        .o_y_value    (y_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Helpers (stimulus only)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rf(input int idx, input logic [15:0] v);
        force_en  = 1'b1;
        force_val = v;
        bus_sel   = 4'(NREG + 1);
        rf_sel    = idx[2:0];
        rf_load   = 1'b1;
        tick();
        rf_load   = 1'b0;
        force_en  = 1'b0;
    endtask

    task automatic load_ac(input logic [15:0] v);
        force_en  = 1'b1;
        force_val = v;
        bus_sel   = 4'(NREG + 1);
        alu_op    = 3'd5;
        ac_load   = 1'b1;
        tick();
        ac_load   = 1'b0;
        force_en  = 1'b0;
    endtask

    task automatic load_ar(input logic [11:0] v);
        force_en  = 1'b1;
        force_val = 16'(v);
        bus_sel   = 4'(NREG + 1);
        ar_load   = 1'b1;
        tick();
        ar_load   = 1'b0;
        force_en  = 1'b0;
    endtask

    function automatic logic [15:0] fit_model(input longint s);
`ifdef CNN_MAC_SAT_EN
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return s[15:0];
    endfunction

    // Starts a MAC and observes it until mac_done (bounded). Returns the done
    // cycle (-1 on timeout), the number of cycles whose busy level was wrong,
    // and AC in the done cycle.
    task automatic run_mac(input logic [3:0] taps, output int done_cyc,
                           output int busy_bad, output logic [15:0] ac_at_done);
        mac_taps   = taps;
        mac_start  = 1'b1;
        tick();
        mac_start  = 1'b0;
        done_cyc   = -1;
        busy_bad   = 0;
        ac_at_done = 'x;
        for (int c = 1; c <= 40; c++) begin
            if (busy !== (c <= 2 * int'(taps))) busy_bad++;
            if (mac_done === 1'b1) begin
                done_cyc   = c;
                ac_at_done = ac_value;
                break;
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus_sel = 4'(NREG);
        #1;
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (mac_done !== 1'b0)   begin errors++; $display("FAIL reset_mac_done got %b want 0", mac_done); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        checks++; if (mem_rd !== 1'b0)     begin errors++; $display("FAIL reset_mem_rd got %b want 0", mem_rd); end
        checks++; if (mem_addr !== 12'h0)  begin errors++; $display("FAIL reset_mem_addr got %h want 000", mem_addr); end
        checks++; if (ac_value !== 16'h0)  begin errors++; $display("FAIL reset_ac got %h want 0000", ac_value); end
        checks++; if (pc_value !== 12'h0)  begin errors++; $display("FAIL reset_pc got %h want 000", pc_value); end
        checks++; if ({y_value, x_value} !== 16'h0) begin errors++; $display("FAIL reset_xy got %h want 0000", {y_value, x_value}); end
        checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_bus_ac got %h want 0000", mem_wdata); end
        for (int i = 0; i < NREG; i++) begin
            bus_sel = 4'(i);
            #1;
            checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_rf%0d got %h want 0000", i, mem_wdata); end
        end
    endtask

    task automatic test_alu();
        logic [15:0] exp_tab [8] = '{16'h8004, 16'h7FFE, 16'h0001, 16'h8003,
                                     16'h8002, 16'h0003, 16'h0002, 16'hC000};
        load_rf(2, 16'h0003);
        bus_sel = 4'd2;
        #1;
        checks++; if (mem_wdata !== 16'h0003) begin errors++; $display("FAIL bus_rf2 got %h want 0003", mem_wdata); end
        bus_sel = 4'd15;
        #1;
        checks++; if (mem_wdata !== 16'h0000) begin errors++; $display("FAIL bus_out_of_range got %h want 0000", mem_wdata); end
        for (int op = 0; op < 8; op++) begin
            load_ac(16'h8001);
            bus_sel = 4'd2;
            alu_op  = op[2:0];
            ac_load = 1'b1;
            tick();
            ac_load = 1'b0;
            checks++;
            if (ac_value !== exp_tab[op]) begin
                errors++;
                $display("FAIL alu_op%0d got %h want %h", op, ac_value, exp_tab[op]);
            end
        end
    endtask

    task automatic test_pc();
        force_en  = 1'b1;
        force_val = 16'h0ABC;
        bus_sel   = 4'(NREG + 1);
        pc_load   = 1'b1;
        pc_inc    = 1'b1;
        tick();
        pc_load   = 1'b0;
        force_en  = 1'b0;
        checks++; if (pc_value !== 12'hABC) begin errors++; $display("FAIL pc_load_priority got %h want abc", pc_value); end
        tick();
        pc_inc    = 1'b0;
        checks++; if (pc_value !== 12'hABD) begin errors++; $display("FAIL pc_inc got %h want abd", pc_value); end
        bus_sel = 4'(NREG + 2);
        #1;
        checks++; if (mem_wdata !== 16'h0ABD) begin errors++; $display("FAIL bus_pc got %h want 0abd", mem_wdata); end
    endtask

    task automatic test_ar_inc();
        load_ar(12'hFFF);
        ar_inc = 1'b1;
        tick();
        ar_inc = 1'b0;
        checks++; if (mem_addr !== 12'h000) begin errors++; $display("FAIL ar_inc_wrap got %h want 000", mem_addr); end
    endtask

    task automatic test_mac_signed();
        int dc, bb;
        logic [15:0] acv, e;
        load_rf(0, 16'h0003);
        load_rf(1, 16'hFFFE);
        mem[12'h100] = 16'd10;
        mem[12'h102] = 16'd5;
        load_ar(12'h100);
        ar_stride = 12'd2;
        exp_q.push_back(fit_model(longint'(10) * 3 + longint'(5) * -2));
        run_mac(4'd2, dc, bb, acv);
        checks++; if (dc != 5) begin errors++; $display("FAIL mac_signed_done_cycle got %0d want 5", dc); end
        checks++; if (bb != 0) begin errors++; $display("FAIL mac_signed_busy got %0d bad cycles want 0", bb); end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL mac_signed_ac got empty queue want entry");
        end else begin
            e = exp_q.pop_front();
            if (acv !== e) begin errors++; $display("FAIL mac_signed_ac got %h want %h", acv, e); end
        end
        checks++; if (mem_addr !== 12'h104) begin errors++; $display("FAIL mac_signed_ar got %h want 104", mem_addr); end
        tick();
        checks++; if (mac_done !== 1'b0) begin errors++; $display("FAIL mac_done_width got %b want 0", mac_done); end
    endtask

    task automatic test_saturation();
        int dc, bb;
        logic [15:0] acv, e;
        load_rf(0, 16'h7FFF);
        mem[12'h200] = 16'h7FFF;
        load_ar(12'h200);
        ar_stride = 12'd1;
        exp_q.push_back(fit_model(longint'(32767) * 32767));
        run_mac(4'd1, dc, bb, acv);
        checks++; if (dc != 3) begin errors++; $display("FAIL sat_done_cycle got %0d want 3", dc); end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL sat_ac got empty queue want entry");
        end else begin
            e = exp_q.pop_front();
            if (acv !== e) begin errors++; $display("FAIL sat_ac got %h want %h", acv, e); end
        end
    endtask

    task automatic test_taps_zero();
        int dc, bb;
        logic [15:0] acv, e;
        load_ac(16'h1234);
        exp_q.push_back(16'h0000);
        run_mac(4'd0, dc, bb, acv);
        checks++; if (dc != 1) begin errors++; $display("FAIL taps0_done_cycle got %0d want 1", dc); end
        checks++; if (bb != 0) begin errors++; $display("FAIL taps0_busy got %0d bad cycles want 0", bb); end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL taps0_ac got empty queue want entry");
        end else begin
            e = exp_q.pop_front();
            if (acv !== e) begin errors++; $display("FAIL taps0_ac got %h want %h", acv, e); end
        end
    endtask

    task automatic test_busy_ignore();
        logic [15:0] rv [4] = '{16'h0002, 16'hFFFF, 16'h0100, 16'h8000};
        logic [15:0] mv [4] = '{16'h1000, 16'h0007, 16'hFF00, 16'h0002};
        longint s;
        int dc, bb;
        logic [15:0] acv, e;
        logic [11:0] pc0;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            load_rf(i, rv[i]);
            mem[12'h300 + 12'(3 * i)] = mv[i];
            s += longint'($signed(rv[i])) * longint'($signed(mv[i]));
        end
        load_ar(12'h300);
        ar_stride = 12'd3;
        pc0 = pc_value;
        exp_q.push_back(fit_model(s));
        mac_taps  = 4'd4;
        mac_start = 1'b1;
        tick();
        mac_start = 1'b0;
        dc = -1;
        bb = 0;
        acv = 'x;
        for (int c = 1; c <= 40; c++) begin
            if (busy !== (c <= 8)) bb++;
            if (mac_done === 1'b1) begin
                dc  = c;
                acv = ac_value;
                break;
            end
            if (c == 2) begin
                bus_sel   = 4'(NREG + 2);
                ar_load   = 1'b1;
                rf_load   = 1'b1;
                rf_sel    = 3'd0;
                ac_load   = 1'b1;
                alu_op    = 3'd5;
                pc_inc    = 1'b1;
                mac_start = 1'b1;
                mac_taps  = 4'd1;
            end else begin
                ar_load   = 1'b0;
                rf_load   = 1'b0;
                ac_load   = 1'b0;
                pc_inc    = 1'b0;
                mac_start = 1'b0;
            end
            tick();
        end
        checks++; if (dc != 9) begin errors++; $display("FAIL busy_ignore_done_cycle got %0d want 9", dc); end
        checks++; if (bb != 0) begin errors++; $display("FAIL busy_ignore_busy got %0d bad cycles want 0", bb); end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL busy_ignore_ac got empty queue want entry");
        end else begin
            e = exp_q.pop_front();
            if (acv !== e) begin errors++; $display("FAIL busy_ignore_ac got %h want %h", acv, e); end
        end
        checks++; if (mem_addr !== 12'h30C) begin errors++; $display("FAIL busy_ignore_ar got %h want 30c", mem_addr); end
        checks++; if (pc_value !== pc0 + 12'd1) begin errors++; $display("FAIL busy_pc_runs got %h want %h", pc_value, pc0 + 12'd1); end
        tick();
        checks++; if ({busy, mac_done} !== 2'b00) begin errors++; $display("FAIL busy_no_restart got %b want 00", {busy, mac_done}); end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        logic [15:0] a1, a2, e;
        load_rf(0, 16'd5);
        mem[12'h400] = 16'd7;
        mem[12'h401] = 16'hFFFD;
        load_ar(12'h400);
        ar_stride = 12'd1;
        exp_q.push_back(fit_model(longint'(5) * 7));
        exp_q.push_back(fit_model(longint'(5) * -3));
        mac_taps  = 4'd1;
        mac_start = 1'b1;
        tick();
        mac_start = 1'b0;
        d1 = -1; d2 = -1; a1 = 'x; a2 = 'x;
        for (int c = 1; c <= 40; c++) begin
            mac_start = 1'b0;
            if (mac_done === 1'b1) begin
                if (d1 < 0) begin
                    d1 = c; a1 = ac_value;
                    mac_start = 1'b1;
                end else begin
                    d2 = c; a2 = ac_value;
                    break;
                end
            end
            tick();
        end
        mac_start = 1'b0;
        checks++; if (d1 != 3) begin errors++; $display("FAIL b2b_first_done got %0d want 3", d1); end
        checks++; if (d2 != 6) begin errors++; $display("FAIL b2b_second_done got %0d want 6", d2); end
        checks++;
        if (exp_q.size() < 2) begin
            errors++; $display("FAIL b2b_ac got %0d queue entries want 2", exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (a1 !== e) begin errors++; $display("FAIL b2b_ac1 got %h want %h", a1, e); end
            checks++;
            e = exp_q.pop_front();
            if (a2 !== e) begin errors++; $display("FAIL b2b_ac2 got %h want %h", a2, e); end
        end
    endtask

    task automatic test_scan();
        logic [7:0] ex [6] = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0};
        logic [7:0] ey [6] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0};
        x_max  = 8'd2;
        y_max  = 8'd1;
        xy_clr = 1'b1;
        tick();
        xy_clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            xy_step = 1'b1;
            tick();
            xy_step = 1'b0;
            checks++;
            if ({y_value, x_value} !== {ey[i], ex[i]}) begin
                errors++;
                $display("FAIL scan_step%0d got y%0d x%0d want y%0d x%0d", i + 1, y_value, x_value, ey[i], ex[i]);
            end
            checks++;
            if (frame_done !== (i == 5)) begin
                errors++;
                $display("FAIL scan_frame_done%0d got %b want %b", i + 1, frame_done, (i == 5));
            end
        end
        tick();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_pulse got %b want 0", frame_done); end
        xy_step = 1'b1;
        tick();
        tick();
        tick();
        xy_step = 1'b0;
        bus_sel = 4'(NREG + 3);
        #1;
        checks++; if (mem_wdata !== 16'h0100) begin errors++; $display("FAIL bus_xy got %h want 0100", mem_wdata); end
        xy_clr  = 1'b1;
        xy_step = 1'b1;
        tick();
        xy_clr  = 1'b0;
        xy_step = 1'b0;
        checks++; if ({y_value, x_value} !== 16'h0) begin errors++; $display("FAIL scan_clr_priority got %h want 0000", {y_value, x_value}); end
    endtask

    task automatic test_reset_mid_mac();
        int dones;
        for (int i = 0; i < 4; i++) mem[12'h500 + 12'(i)] = 16'(i + 1);
        load_ar(12'h500);
        ar_stride = 12'd1;
        load_ac(16'h5555);
        xy_step = 1'b1;
        tick();
        xy_step = 1'b0;
        mac_taps  = 4'd4;
        mac_start = 1'b1;
        tick();
        mac_start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        checks++; if (ac_value !== 16'h0) begin errors++; $display("FAIL rst_mid_ac got %h want 0000", ac_value); end
        checks++; if (mem_addr !== 12'h0) begin errors++; $display("FAIL rst_mid_ar got %h want 000", mem_addr); end
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            if (mac_done !== 1'b0 || busy !== 1'b0) dones++;
            tick();
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL rst_mid_no_done got %0d active cycles want 0", dones); end
        bus_sel = 4'(NREG + 3);
        #1;
        checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL rst_mid_bus_xy got %h want 0000", mem_wdata); end
    endtask

    // ------------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------------
    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus_sel   = '0;
        rf_load   = 1'b0;
        rf_sel    = '0;
        ac_load   = 1'b0;
        alu_op    = '0;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        ar_load   = 1'b0;
        ar_inc    = 1'b0;
        ar_stride = '0;
        xy_step   = 1'b0;
        xy_clr    = 1'b0;
        x_max     = '0;
        y_max     = '0;
        mac_start = 1'b0;
        mac_taps  = '0;
        force_en  = 1'b0;
        force_val = '0;
        for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;

        test_reset();
        test_alu();
        test_pc();
        test_ar_inc();
        test_mac_signed();
        test_saturation();
        test_taps_zero();
        test_busy_ignore();
        test_back_to_back();
        test_scan();
        test_reset_mid_mac();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
